// File: rtl/onehot_dispatch.sv
// Handshaked address-to-select dispatcher: decodes a request into a registered
// one-hot or all-ones select, holds it until acknowledged, and can sweep upward.
module onehot_dispatch #(
  parameter int ADDR_W = 4,
  parameter int N_OUT  = 12,
  parameter int BASE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_mode,
  output logic [N_OUT-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              err,
  output logic              done
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  localparam int               IDX_W     = ADDR_W + 1;
  localparam logic [1:0]       M_SINGLE  = 2'b00;
  localparam logic [1:0]       M_BCAST   = 2'b01;
  localparam logic [1:0]       M_SWEEP   = 2'b10;
  localparam logic [IDX_W-1:0] BASE_X    = IDX_W'(BASE);
  localparam logic [IDX_W-1:0] LAST_X    = IDX_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] SEL_FIRST = {1'b1, {(N_OUT-1){1'b0}}};

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_mode;
  logic [N_OUT-1:0] r_sel;
  logic             r_valid;
  logic             r_err;
  logic             r_done;

  logic [IDX_W-1:0] w_addr_x;
  logic [IDX_W-1:0] w_idx;
  logic             w_addr_ok;
  logic             w_accept;
  logic             w_start;
  logic             w_reject;
  logic [N_OUT-1:0] w_onehot;

  // Extra headroom bit keeps addresses below BASE from wrapping into range.
  assign w_addr_x  = {1'b0, req_addr};
  assign w_idx     = w_addr_x - BASE_X;
  assign w_addr_ok = (w_addr_x >= BASE_X) && (w_idx <= LAST_X);
  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_start   = w_accept &&
                     ((req_mode == M_BCAST) ||
                      (((req_mode == M_SINGLE) || (req_mode == M_SWEEP)) && w_addr_ok));
  assign w_reject  = w_accept && !w_start;
  assign w_onehot  = SEL_FIRST >> w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_mode  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_ACTIVE;
            r_idx   <= w_idx;
            r_mode  <= req_mode;
            r_valid <= 1'b1;
            r_sel   <= (req_mode == M_BCAST) ? '1 : w_onehot;
          end else if (w_reject) begin
            r_err <= 1'b1;
          end
        end
        S_ACTIVE: begin
          // A sweep advances one destination per ack; anything else finishes.
          if (out_ack) begin
            if ((r_mode == M_SWEEP) && (r_idx != LAST_X)) begin
              r_idx <= r_idx + 1'b1;
              r_sel <= r_sel >> 1;
            end else begin
              r_state <= S_IDLE;
              r_idx   <= '0;
              r_mode  <= '0;
              r_sel   <= '0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign out_sel   = r_sel;
  assign out_valid = r_valid;
  assign err       = r_err;
  assign done      = r_done;

endmodule

// File: tb/tb_onehot_dispatch.sv
// Bench for onehot_dispatch: directed scenarios plus randomized requests checked
// against a transaction-level model of the expected select sequence.
module tb_onehot_dispatch;

  localparam int ADDR_W = 4;
  localparam int N_OUT  = 12;
  localparam int BASE   = 1;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_mode;
  logic [N_OUT-1:0]  out_sel;
  logic              out_valid;
  logic              out_ack;
  logic              err;
  logic              done;

  int n_chk;
  int n_err;

  onehot_dispatch #(.ADDR_W(ADDR_W), .N_OUT(N_OUT), .BASE(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_mode  (req_mode),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .err       (err),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected select for destination j: first destination is the MSB.
  function automatic logic [N_OUT-1:0] sel_of(input int j);
    logic [N_OUT-1:0] s;
    s = '0;
    s[N_OUT-1-j] = 1'b1;
    return s;
  endfunction

  // ack_kind: 0 random, 1 tied high, 2 low one cycle then high, 3 low three cycles then high
  task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic [1:0] mode,
                         input int ack_kind, input bit idle_after);
    logic [N_OUT-1:0] q[$];
    int  idx;
    bit  reject;
    int  cnt;
    int  steps;
    logic a;
    idx    = int'(addr) - BASE;
    reject = (mode == 2'b11) || ((mode != 2'b01) && !(idx >= 0 && idx < N_OUT));
    q = {};
    if (!reject) begin
      if (mode == 2'b01)      q.push_back('1);
      else if (mode == 2'b00) q.push_back(sel_of(idx));
      else for (int j = idx; j < N_OUT; j++) q.push_back(sel_of(j));
    end

    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_mode  = mode;
    out_ack   = (ack_kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    req_valid = 1'b0;
    out_ack   = 1'b0;

    if (reject) begin
      chk("rej_err", err, 1'b1);
      chk("rej_valid", out_valid, 1'b0);
      chk("rej_sel", out_sel, '0);
      chk("rej_ready", req_ready, 1'b1);
      chk("rej_done", done, 1'b0);
    end else begin
      cnt   = 0;
      steps = 0;
      while (q.size() > 0 && steps < 200) begin
        chk("act_valid", out_valid, 1'b1);
        chk("act_sel", out_sel, q[0]);
        chk("act_ready", req_ready, 1'b0);
        chk("act_err", err, 1'b0);
        chk("act_done", done, 1'b0);
        case (ack_kind)
          1:       a = 1'b1;
          2:       a = (cnt >= 1);
          3:       a = (cnt >= 3);
          default: a = 1'($urandom_range(0, 1));
        endcase
        out_ack = a;
        if (ack_kind == 0) begin
          req_valid = 1'($urandom_range(0, 1));
          req_addr  = ADDR_W'($urandom);
          req_mode  = 2'($urandom);
        end
        tick();
        steps++;
        if (a) begin
          void'(q.pop_front());
          cnt = 0;
        end else begin
          cnt++;
        end
      end
      chk("txn_remaining", q.size(), 0);
      req_valid = 1'b0;
      out_ack   = 1'b0;
      chk("end_valid", out_valid, 1'b0);
      chk("end_sel", out_sel, '0);
      chk("end_done", done, 1'b1);
      chk("end_ready", req_ready, 1'b1);
      chk("end_err", err, 1'b0);
    end

    if (idle_after) begin
      out_ack = 1'($urandom_range(0, 1));
      tick();
      out_ack = 1'b0;
      chk("idle_done", done, 1'b0);
      chk("idle_err", err, 1'b0);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_sel", out_sel, '0);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_mode  = '0;
    out_ack   = 1'b0;

    #2;
    chk("rst_sel", out_sel, 12'h000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_txn(4'd1, 2'b00, 3, 1'b1);
    run_txn(4'd12, 2'b00, 1, 1'b1);
    run_txn(4'd0, 2'b00, 1, 1'b1);
    run_txn(4'd13, 2'b00, 1, 1'b1);
    run_txn(4'd15, 2'b00, 1, 1'b1);
    run_txn(4'd5, 2'b11, 1, 1'b1);
    run_txn(4'd0, 2'b01, 3, 1'b1);
    run_txn(4'd10, 2'b10, 1, 1'b1);
    run_txn(4'd1, 2'b10, 2, 1'b0);
    run_txn(4'd12, 2'b10, 1, 1'b1);

    // Abandon a sweep at the sixth destination with an asynchronous reset.
    req_valid = 1'b1;
    req_addr  = 4'd1;
    req_mode  = 2'b10;
    tick();
    req_valid = 1'b0;
    out_ack   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ack = 1'b0;
    chk("mid_sel", out_sel, 12'h040);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", out_sel, 12'h000);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_valid", out_valid, 1'b0);
    run_txn(4'd3, 2'b00, 1, 1'b1);

    for (int t = 0; t < 300; t++) begin
      run_txn(ADDR_W'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
